// File: rtl/pc_fetch_controller.sv
// pc_fetch_controller
//   Program counter owner for the IF stage of the MIPS pipeline. Steps the PC by
//   one word per fetch, applies decode-stage redirects (immediately or deferred
//   across stalls / debug holds), issues the IF/ID flush on a taken redirect and
//   stops permanently on a fetched HALT until reset.
//
//   Optional feature macro: BRANCH_DELAY_SLOT_EN
//     undefined : a taken redirect flushes IF/ID; branch beats a same-cycle halt.
//     defined   : no flush (the IF instruction is a delay slot); a same-cycle
//                 halt wins and the redirect is discarded.

module pc_fetch_controller #(
    parameter int CANT_BITS_ADDR  = 11,
    parameter int CANT_BITS_COUNT = 32
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_stall,
    input  logic                       i_branch_control,
    input  logic [CANT_BITS_ADDR-1:0]  i_branch_dir,
    input  logic                       i_halt_detected,
    output logic [CANT_BITS_ADDR-1:0]  o_pc,
    output logic [CANT_BITS_ADDR-1:0]  o_adder_pc,
    output logic                       o_flush_if_id,
    output logic                       o_valid,
    output logic                       o_halted,
    output logic [CANT_BITS_COUNT-1:0] o_fetch_count
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PENDING = 2'd1,
        ST_HALTED  = 2'd2
    } fetch_state_e;

    localparam logic [CANT_BITS_ADDR-1:0]  PC_ONE    = {{(CANT_BITS_ADDR-1){1'b0}}, 1'b1};
    localparam logic [CANT_BITS_COUNT-1:0] COUNT_ONE = {{(CANT_BITS_COUNT-1){1'b0}}, 1'b1};

    fetch_state_e                 state_q, state_d;
    logic [CANT_BITS_ADDR-1:0]    pc_q, pc_d;
    logic [CANT_BITS_ADDR-1:0]    target_q, target_d;
    logic [CANT_BITS_COUNT-1:0]   count_q, count_d;
    logic                         advance;
    logic                         redirect;
    logic [CANT_BITS_ADDR-1:0]    pc_plus_one;

    assign pc_plus_one = pc_q + PC_ONE;
    assign advance     = i_enable & ~i_stall & (state_q != ST_HALTED);

    // Next-state selection: redirect / pending target / halt / sequential step when
    // advancing, otherwise capture any redirect that arrives during a hold.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        count_d  = count_q;
        redirect = 1'b0;

        if (advance) begin
`ifdef BRANCH_DELAY_SLOT_EN
            if (i_branch_control && i_halt_detected) begin
                state_d = ST_HALTED;
            end else
`endif
            if (i_branch_control) begin
                pc_d     = i_branch_dir;
                state_d  = ST_RUN;
                redirect = 1'b1;
            end else if (state_q == ST_PENDING) begin
                pc_d     = target_q;
                state_d  = ST_RUN;
                redirect = 1'b1;
            end else if (i_halt_detected) begin
                state_d = ST_HALTED;
            end else begin
                pc_d = pc_plus_one;
            end

            if (pc_d != pc_q) begin
                count_d = count_q + COUNT_ONE;
            end
        end else if (state_q != ST_HALTED) begin
            if (i_branch_control) begin
                target_d = i_branch_dir;
                state_d  = ST_PENDING;
            end
        end
    end

    // State, PC, latched redirect target and fetch counter; reset clears all at once.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= ST_RUN;
            pc_q     <= '0;
            target_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            count_q  <= count_d;
        end
    end

`ifdef BRANCH_DELAY_SLOT_EN
    // The delay-slot instruction always proceeds, so nothing is ever flushed.
    assign o_flush_if_id = 1'b0;
    logic unusedRedirect;
    assign unusedRedirect = redirect;
`else
    assign o_flush_if_id = advance & redirect;
`endif

    assign o_pc          = pc_q;
    assign o_adder_pc    = pc_plus_one;
    assign o_valid       = (state_q != ST_HALTED);
    assign o_halted      = (state_q == ST_HALTED);
    assign o_fetch_count = count_q;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// tb_pc_fetch_controller
//   Table of per-cycle vectors for pc_fetch_controller plus hand sequences for
//   asynchronous reset, pending-target clearing and branch+halt collisions.
//   Honours BRANCH_DELAY_SLOT_EN when the bench is built with it.

module tb_pc_fetch_controller;

    localparam int AW = 11;
    localparam int CW = 32;

    logic          clock;
    logic          i_reset;
    logic          i_enable;
    logic          i_stall;
    logic          i_branch_control;
    logic [AW-1:0] i_branch_dir;
    logic          i_halt_detected;
    logic [AW-1:0] o_pc;
    logic [AW-1:0] o_adder_pc;
    logic          o_flush_if_id;
    logic          o_valid;
    logic          o_halted;
    logic [CW-1:0] o_fetch_count;

    typedef struct {
        logic          en;
        logic          stall;
        logic          br;
        logic [AW-1:0] dir;
        logic          halt;
        logic [AW-1:0] expPc;
        logic          expFlush;
        logic          expValid;
        logic          expHalted;
        logic [CW-1:0] expCount;
    } vec_t;

    typedef struct {
        logic [AW-1:0] expPc;
        logic          expValid;
        logic          expHalted;
        logic [CW-1:0] expCount;
        int            tag;
    } exp_t;

    vec_t vecs[$];
    exp_t scoreboard[$];
    int   errorCount = 0;
    int   checkCount = 0;

    pc_fetch_controller #(.CANT_BITS_ADDR(AW), .CANT_BITS_COUNT(CW)) dut (
        .i_clock          (clock),
        .i_reset          (i_reset),
        .i_enable         (i_enable),
        .i_stall          (i_stall),
        .i_branch_control (i_branch_control),
        .i_branch_dir     (i_branch_dir),
        .i_halt_detected  (i_halt_detected),
        .o_pc             (o_pc),
        .o_adder_pc       (o_adder_pc),
        .o_flush_if_id    (o_flush_if_id),
        .o_valid          (o_valid),
        .o_halted         (o_halted),
        .o_fetch_count    (o_fetch_count)
    );

    // Free-running 10-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic addVec(input logic en, input logic stall, input logic br, input logic [AW-1:0] dir,
                          input logic halt, input logic [AW-1:0] expPc, input logic expFlush,
                          input logic expValid, input logic expHalted, input logic [CW-1:0] expCount);
        vec_t v;
        v.en = en; v.stall = stall; v.br = br; v.dir = dir; v.halt = halt;
        v.expPc = expPc; v.expFlush = expFlush; v.expValid = expValid;
        v.expHalted = expHalted; v.expCount = expCount;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, check the combinational flush, queue the registered result.
    task automatic applyStimulus(input vec_t v, input int tag);
        exp_t e;
        logic flushReq;
        i_enable         = v.en;
        i_stall          = v.stall;
        i_branch_control = v.br;
        i_branch_dir     = v.dir;
        i_halt_detected  = v.halt;
        flushReq         = v.expFlush;
`ifdef BRANCH_DELAY_SLOT_EN
        flushReq         = 1'b0;
`endif
        #1;
        checkValue($sformatf("flush[%0d]", tag), {31'd0, o_flush_if_id}, {31'd0, flushReq});
        e.expPc = v.expPc; e.expValid = v.expValid; e.expHalted = v.expHalted;
        e.expCount = v.expCount; e.tag = tag;
        scoreboard.push_back(e);
    endtask

    // Pop the oldest expectation and compare the registered outputs against it.
    task automatic checkOutput();
        exp_t e;
        logic [AW-1:0] expAdder;
        if (scoreboard.size() == 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL scoreboard: actual=empty required=entry");
            return;
        end
        e = scoreboard.pop_front();
        expAdder = e.expPc + 11'd1;
        checkValue($sformatf("pc[%0d]", e.tag),     {21'd0, o_pc},       {21'd0, e.expPc});
        checkValue($sformatf("adder[%0d]", e.tag),  {21'd0, o_adder_pc}, {21'd0, expAdder});
        checkValue($sformatf("valid[%0d]", e.tag),  {31'd0, o_valid},    {31'd0, e.expValid});
        checkValue($sformatf("halted[%0d]", e.tag), {31'd0, o_halted},   {31'd0, e.expHalted});
        checkValue($sformatf("count[%0d]", e.tag),  o_fetch_count,       e.expCount);
    endtask

    task automatic runCycle(input vec_t v, input int tag);
        applyStimulus(v, tag);
        @(posedge clock);
        #1;
        checkOutput();
        @(negedge clock);
    endtask

    task automatic checkResetValues(input string pfx);
        checkValue({pfx, "_pc"},     {21'd0, o_pc},       32'd0);
        checkValue({pfx, "_adder"},  {21'd0, o_adder_pc}, 32'd1);
        checkValue({pfx, "_valid"},  {31'd0, o_valid},    32'd1);
        checkValue({pfx, "_halted"}, {31'd0, o_halted},   32'd0);
        checkValue({pfx, "_count"},  o_fetch_count,       32'd0);
        checkValue({pfx, "_flush"},  {31'd0, o_flush_if_id}, 32'd0);
    endtask

    task automatic setIdle();
        i_enable = 1'b0; i_stall = 1'b0; i_branch_control = 1'b0;
        i_branch_dir = '0; i_halt_detected = 1'b0;
    endtask

    // Main sequence: reset, table vectors, then hand-written corner cases.
    initial begin
        vec_t v;
        setIdle();
        i_reset = 1'b0;

        // en stall br dir halt | pc flush valid halted count
        for (int i = 1; i <= 7; i++)
            addVec(1, 0, 0, 11'h000, 0, AW'(i), 0, 1, 0, CW'(i));
        addVec(1, 0, 1, 11'h040, 0, 11'h040, 1, 1, 0, 8);   // redirect from pc 7
        addVec(1, 1, 1, 11'h123, 0, 11'h040, 0, 1, 0, 8);   // stall captures target
        addVec(1, 1, 0, 11'h000, 0, 11'h040, 0, 1, 0, 8);
        addVec(1, 1, 0, 11'h000, 0, 11'h040, 0, 1, 0, 8);
        addVec(1, 0, 0, 11'h000, 0, 11'h123, 1, 1, 0, 9);   // pending applied
        addVec(1, 0, 0, 11'h000, 0, 11'h124, 0, 1, 0, 10);
        addVec(0, 0, 1, 11'h200, 0, 11'h124, 0, 1, 0, 10);  // debug hold captures
        addVec(0, 0, 1, 11'h300, 0, 11'h124, 0, 1, 0, 10);  // overwritten target
        addVec(1, 0, 0, 11'h000, 0, 11'h300, 1, 1, 0, 11);
        addVec(1, 0, 1, 11'h7FF, 0, 11'h7FF, 1, 1, 0, 12);
        addVec(1, 0, 0, 11'h000, 0, 11'h000, 0, 1, 0, 13);  // wrap to 0
        addVec(1, 0, 1, 11'h009, 0, 11'h009, 1, 1, 0, 14);
        addVec(1, 0, 0, 11'h000, 1, 11'h009, 0, 0, 1, 14);  // halt at pc 9
        addVec(1, 0, 1, 11'h020, 0, 11'h009, 0, 0, 1, 14);  // ignored while halted
        addVec(0, 1, 1, 11'h055, 0, 11'h009, 0, 0, 1, 14);
        addVec(1, 0, 0, 11'h000, 0, 11'h009, 0, 0, 1, 14);

        repeat (2) @(negedge clock);
        #1;
        checkResetValues("reset");
        @(negedge clock);
        i_reset = 1'b1;

        foreach (vecs[i]) runCycle(vecs[i], i);

        // Asynchronous reset out of HALTED, mid-cycle.
        setIdle();
        #2;
        i_reset = 1'b0;
        #1;
        checkResetValues("areset1");
        @(negedge clock);
        i_reset = 1'b1;

        // Capture a pending target, then reset must discard it.
        v = '{en:1, stall:1, br:1, dir:11'h055, halt:0, expPc:0, expFlush:0, expValid:1, expHalted:0, expCount:0};
        runCycle(v, 100);
        setIdle();
        #2;
        i_reset = 1'b0;
        #1;
        checkResetValues("areset2");
        @(negedge clock);
        i_reset = 1'b1;
        v = '{en:1, stall:0, br:0, dir:0, halt:0, expPc:1, expFlush:0, expValid:1, expHalted:0, expCount:1};
        runCycle(v, 101);

        // Branch and halt in the same advancing cycle.
`ifdef BRANCH_DELAY_SLOT_EN
        v = '{en:1, stall:0, br:1, dir:11'h030, halt:1, expPc:1, expFlush:0, expValid:0, expHalted:1, expCount:1};
        runCycle(v, 102);
        v = '{en:1, stall:0, br:0, dir:0, halt:0, expPc:1, expFlush:0, expValid:0, expHalted:1, expCount:1};
        runCycle(v, 103);
`else
        v = '{en:1, stall:0, br:1, dir:11'h030, halt:1, expPc:11'h030, expFlush:1, expValid:1, expHalted:0, expCount:2};
        runCycle(v, 102);
        v = '{en:1, stall:0, br:0, dir:0, halt:0, expPc:11'h031, expFlush:0, expValid:1, expHalted:0, expCount:3};
        runCycle(v, 103);
`endif

        if (scoreboard.size() != 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL scoreboard_drain: actual=%0d required=0", scoreboard.size());
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
